// File: rtl/ysyx_25040111_lsu_pkg.sv
// Shared encodings for the LSU-to-AXI4 bridge: access masks, FSM states and AXI constants.
package ysyx_25040111_lsu_pkg;

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4
    } lsu_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [2:0] SIZE_1 = 3'd0;
    localparam logic [2:0] SIZE_2 = 3'd1;
    localparam logic [2:0] SIZE_4 = 3'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Both 2'b10 and 2'b11 are word accesses.
    function automatic logic [2:0] mask_to_size(input logic [1:0] mask);
        logic [2:0] size;
        case (mask)
            MASK_B:  size = SIZE_1;
            MASK_H:  size = SIZE_2;
            default: size = SIZE_4;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/ysyx_25040111_lsu_align.sv
// Combinational lane logic: load byte/half extract with zero/sign extension,
// store lane replication and WSTRB generation.
module ysyx_25040111_lsu_align
    import ysyx_25040111_lsu_pkg::*;
(
    input  logic [31:0] i_rdata_raw,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_mask,
    input  logic        i_sign,
    input  logic        i_burst,
    input  logic [31:0] i_wdata_raw,
    output logic [31:0] o_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shifted = i_rdata_raw >> {i_addr_lo, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted[15:0];

    // Refill beats are whole cache words and never get extracted.
    always_comb begin
        o_rdata = i_rdata_raw;
        if (i_burst) begin
            o_rdata = i_rdata_raw;
        end else begin
            case (i_mask)
                MASK_B:  o_rdata = {{24{i_sign & w_byte[7]}}, w_byte};
                MASK_H:  o_rdata = {{16{i_sign & w_half[15]}}, w_half};
                default: o_rdata = i_rdata_raw;
            endcase
        end
    end

    always_comb begin
        o_wdata = i_wdata_raw;
        o_wstrb = 4'b1111;
        case (i_mask)
            MASK_B: begin
                o_wdata = {4{i_wdata_raw[7:0]}};
                o_wstrb = 4'b0001 << i_addr_lo;
            end
            MASK_H: begin
                o_wdata = {2{i_wdata_raw[15:0]}};
                o_wstrb = 4'b0011 << i_addr_lo;
            end
            default: begin
                o_wdata = i_wdata_raw;
                o_wstrb = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25040111_lsu_axi_bridge.sv
// LSU request responder issuing one AXI4 master transaction per accepted load/store.
// Optional YSYX_LSU_ACCESS_ERR_EN adds access_err / access_err_addr response reporting.
module ysyx_25040111_lsu_axi_bridge
    import ysyx_25040111_lsu_pkg::*;
#(
    parameter int ID_W  = 4,
    parameter int RD_ID = 0,
    parameter int WR_ID = 1
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            lsu_rvalid,
    output logic            lsu_rready,
    output logic [31:0]     lsu_rdata,
    input  logic [31:0]     lsu_raddr,
    input  logic [7:0]      lsu_rlen,
    input  logic            lsu_burst,
    input  logic [1:0]      lsu_rmask,
    input  logic            lsu_rsign,

    input  logic            lsu_wvalid,
    output logic            lsu_wready,
    input  logic [31:0]     lsu_wdata,
    input  logic [31:0]     lsu_waddr,
    input  logic [1:0]      lsu_wmask,

    output logic            m_arvalid,
    input  logic            m_arready,
    output logic [31:0]     m_araddr,
    output logic [ID_W-1:0] m_arid,
    output logic [7:0]      m_arlen,
    output logic [2:0]      m_arsize,
    output logic [1:0]      m_arburst,

    input  logic            m_rvalid,
    output logic            m_rready,
    input  logic [31:0]     m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic            m_rlast,
    input  logic [ID_W-1:0] m_rid,

    output logic            m_awvalid,
    input  logic            m_awready,
    output logic [31:0]     m_awaddr,
    output logic [ID_W-1:0] m_awid,
    output logic [7:0]      m_awlen,
    output logic [2:0]      m_awsize,
    output logic [1:0]      m_awburst,

    output logic            m_wvalid,
    input  logic            m_wready,
    output logic [31:0]     m_wdata,
    output logic [3:0]      m_wstrb,
    output logic            m_wlast,

    input  logic            m_bvalid,
    output logic            m_bready,
    input  logic [1:0]      m_bresp,
    input  logic [ID_W-1:0] m_bid
`ifdef YSYX_LSU_ACCESS_ERR_EN
    ,
    output logic            access_err,
    output logic [31:0]     access_err_addr
`endif
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nx;

    logic [31:0] r_addr;
    logic [7:0]  r_rlen;
    logic        r_burst;
    logic [1:0]  r_mask;
    logic        r_rsign;
    logic [31:0] r_wdata;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_aw_fire;
    logic        w_w_fire;
    logic        w_ar_fire;
    logic [31:0] w_load_data;
    logic [31:0] w_store_data;
    logic [3:0]  w_store_strb;
    logic        w_unused;

    assign w_ar_fire = m_arvalid && m_arready;
    assign w_aw_fire = m_awvalid && m_awready;
    assign w_w_fire  = m_wvalid && m_wready;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Request capture; a read wins when both requests are present.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr  <= 32'h0000_0000;
            r_rlen  <= 8'h00;
            r_burst <= 1'b0;
            r_mask  <= 2'b00;
            r_rsign <= 1'b0;
            r_wdata <= 32'h0000_0000;
        end else if (r_state == ST_IDLE) begin
            if (lsu_rvalid) begin
                r_addr  <= lsu_raddr;
                r_rlen  <= lsu_rlen;
                r_burst <= lsu_burst;
                r_mask  <= lsu_rmask;
                r_rsign <= lsu_rsign;
            end else if (lsu_wvalid) begin
                r_addr  <= lsu_waddr;
                r_wdata <= lsu_wdata;
                r_mask  <= lsu_wmask;
                r_burst <= 1'b0;
            end
        end
    end

    // AW and W complete independently; the flags remember which already did.
    always_ff @(posedge clock) begin
        if (reset || (r_state != ST_WREQ)) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_fire) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_fire) begin
                r_w_done <= 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (lsu_rvalid) begin
                    w_state_nx = ST_RADDR;
                end else if (lsu_wvalid) begin
                    w_state_nx = ST_WREQ;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RADDR: begin
                if (w_ar_fire) begin
                    w_state_nx = ST_RDATA;
                end else begin
                    w_state_nx = ST_RADDR;
                end
            end
            ST_RDATA: begin
                if (m_rvalid && m_rlast) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_RDATA;
                end
            end
            ST_WREQ: begin
                if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                    w_state_nx = ST_WRESP;
                end else begin
                    w_state_nx = ST_WREQ;
                end
            end
            ST_WRESP: begin
                if (m_bvalid) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_WRESP;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    ysyx_25040111_lsu_align u_align (
        .i_rdata_raw (m_rdata),
        .i_addr_lo   (r_addr[1:0]),
        .i_mask      (r_mask),
        .i_sign      (r_rsign),
        .i_burst     (r_burst),
        .i_wdata_raw (r_wdata),
        .o_rdata     (w_load_data),
        .o_wdata     (w_store_data),
        .o_wstrb     (w_store_strb)
    );

    assign m_arvalid = (r_state == ST_RADDR);
    assign m_araddr  = r_addr;
    assign m_arid    = RD_ID[ID_W-1:0];
    assign m_arlen   = r_burst ? r_rlen : 8'h00;
    assign m_arsize  = r_burst ? SIZE_4 : mask_to_size(r_mask);
    assign m_arburst = BURST_INCR;

    assign m_rready   = (r_state == ST_RDATA);
    assign lsu_rready = m_rready && m_rvalid;
    assign lsu_rdata  = lsu_rready ? w_load_data : 32'h0000_0000;

    assign m_awvalid = (r_state == ST_WREQ) && !r_aw_done;
    assign m_awaddr  = r_addr;
    assign m_awid    = WR_ID[ID_W-1:0];
    assign m_awlen   = 8'h00;
    assign m_awsize  = mask_to_size(r_mask);
    assign m_awburst = BURST_INCR;

    assign m_wvalid = (r_state == ST_WREQ) && !r_w_done;
    assign m_wdata  = w_store_data;
    assign m_wstrb  = w_store_strb;
    assign m_wlast  = 1'b1;

    assign m_bready   = (r_state == ST_WRESP);
    assign lsu_wready = m_bready && m_bvalid;

`ifdef YSYX_LSU_ACCESS_ERR_EN
    logic        r_access_err;
    logic [31:0] r_access_err_addr;
    logic        w_err_hit;

    assign w_err_hit = (m_rvalid && m_rready && m_rresp[1]) ||
                       (m_bvalid && m_bready && m_bresp[1]);

    // SLVERR/DECERR reporting; the address is held until the next error.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_access_err      <= 1'b0;
            r_access_err_addr <= 32'h0000_0000;
        end else begin
            r_access_err <= w_err_hit;
            if (w_err_hit) begin
                r_access_err_addr <= r_addr;
            end
        end
    end

    assign access_err      = r_access_err;
    assign access_err_addr = r_access_err_addr;
`endif

    assign w_unused = ^{m_rresp, m_rid, m_bresp, m_bid};

endmodule

// File: tb/tb_ysyx_25040111_lsu_axi_bridge.sv
// Directed plus randomized bench for the LSU AXI bridge, checked against an arithmetic reference model.
module tb_ysyx_25040111_lsu_axi_bridge;

    logic        clock;
    logic        reset;
    logic        lsu_rvalid, lsu_rready, lsu_burst, lsu_rsign;
    logic [31:0] lsu_rdata, lsu_raddr;
    logic [7:0]  lsu_rlen;
    logic [1:0]  lsu_rmask;
    logic        lsu_wvalid, lsu_wready;
    logic [31:0] lsu_wdata, lsu_waddr;
    logic [1:0]  lsu_wmask;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid, m_rready, m_rlast;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic [3:0]  m_rid;
    logic        m_awvalid, m_awready;
    logic [31:0] m_awaddr;
    logic [3:0]  m_awid;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_wvalid, m_wready, m_wlast;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid, m_bready;
    logic [1:0]  m_bresp;
    logic [3:0]  m_bid;
`ifdef YSYX_LSU_ACCESS_ERR_EN
    logic        access_err;
    logic [31:0] access_err_addr;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit g_dual  = 1'b0;

    ysyx_25040111_lsu_axi_bridge dut (
        .clock(clock), .reset(reset),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
        .lsu_raddr(lsu_raddr), .lsu_rlen(lsu_rlen), .lsu_burst(lsu_burst),
        .lsu_rmask(lsu_rmask), .lsu_rsign(lsu_rsign),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata),
        .lsu_waddr(lsu_waddr), .lsu_wmask(lsu_wmask),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rid(m_rid),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid)
`ifdef YSYX_LSU_ACCESS_ERR_EN
        , .access_err(access_err), .access_err_addr(access_err_addr)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int access_bytes(input logic [1:0] mask);
        return (mask == 2'b00) ? 1 : ((mask == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [2:0] model_size(input logic [1:0] mask);
        int b;
        b = access_bytes(mask);
        return (b == 1) ? 3'd0 : ((b == 2) ? 3'd1 : 3'd2);
    endfunction

    // Loaded value as arithmetic: divide out the lower lanes, keep nbytes, reinterpret as signed if asked.
    function automatic logic [31:0] model_load(input logic [31:0] d, input logic [31:0] addr,
                                               input logic [1:0] mask, input logic sign, input logic burst);
        longint v;
        longint span;
        int     nb;
        if (burst || access_bytes(mask) == 4) return d;
        nb   = access_bytes(mask);
        span = longint'(1) << (8 * nb);
        v    = (longint'(d) / (longint'(1) << (8 * int'(addr[1:0])))) % span;
        if (sign && (v >= span / 2)) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] mask);
        longint v;
        case (access_bytes(mask))
            1:       v = (longint'(d) % 256) * 64'h0101_0101;
            2:       v = (longint'(d) % 65536) * 64'h0001_0001;
            default: v = longint'(d);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] addr, input logic [1:0] mask);
        int v;
        v = ((1 << access_bytes(mask)) - 1) * (1 << int'(addr[1:0]));
        if (access_bytes(mask) == 4) v = 15;
        v = v % 16;
        return v[3:0];
    endfunction

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic burst,
                           input logic [1:0] mask, input logic sign, input logic [31:0] d0,
                           input int ar_delay, input bit gap, input int abort_beat,
                           output logic [31:0] first);
        int n;
        int nbeats;
        logic [31:0] d;
        nbeats = burst ? int'(len) + 1 : 1;
        first  = 32'h0;
        @(negedge clock);
        lsu_rvalid = 1'b1; lsu_raddr = addr; lsu_rlen = len; lsu_burst = burst;
        lsu_rmask = mask; lsu_rsign = sign;
        if (g_dual) lsu_wvalid = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; #1; end while (!m_arvalid && n < 20);
        chk("ar_latency", 32'(n), 32'd1);
        chk("araddr", m_araddr, addr);
        chk("arlen", 32'(m_arlen), burst ? 32'(len) : 32'd0);
        chk("arsize", 32'(m_arsize), burst ? 32'd2 : 32'(model_size(mask)));
        chk("arburst", 32'(m_arburst), 32'd1);
        chk("arid", 32'(m_arid), 32'd0);
        chk1("aw_idle_in_raddr", m_awvalid, 1'b0);
        for (int i = 0; i < ar_delay; i++) begin
            @(negedge clock); #1;
            chk1("arvalid_hold", m_arvalid, 1'b1);
        end
        m_arready = 1'b1;
        @(negedge clock);
        m_arready = 1'b0;
        #1;
        chk1("arvalid_drop", m_arvalid, 1'b0);
        for (int b = 0; b < nbeats; b++) begin
            if (gap && b > 0) begin
                m_rvalid = 1'b0;
                #1;
                chk1("lsu_rready_gap", lsu_rready, 1'b0);
                chk1("m_rready_gap", m_rready, 1'b1);
                @(negedge clock);
            end
            d = (b == 0) ? d0 : $urandom;
            m_rvalid = 1'b1; m_rdata = d; m_rlast = (b == nbeats - 1);
            #1;
            chk1("m_rready", m_rready, 1'b1);
            chk1("lsu_rready_beat", lsu_rready, 1'b1);
            chk("lsu_rdata", lsu_rdata, model_load(d, addr, mask, sign, burst));
            chk1("aw_blocked_by_read", m_awvalid, 1'b0);
            if (b == 0) first = lsu_rdata;
            if (b == abort_beat) begin
                @(negedge clock);
                m_rlast = 1'b0; m_rdata = $urandom; reset = 1'b1; lsu_rvalid = 1'b0;
                @(negedge clock); #1;
                chk1("rst_m_rready", m_rready, 1'b0);
                chk1("rst_lsu_rready", lsu_rready, 1'b0);
                chk("rst_lsu_rdata", lsu_rdata, 32'h0);
                chk1("rst_arvalid", m_arvalid, 1'b0);
                m_rvalid = 1'b0; reset = 1'b0;
                return;
            end
            @(negedge clock);
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; lsu_rvalid = 1'b0;
        #1;
        chk1("idle_m_rready", m_rready, 1'b0);
        chk1("idle_lsu_rready", lsu_rready, 1'b0);
        chk1("idle_awvalid", m_awvalid, 1'b0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] mask,
                            input int aw_delay, input int w_delay, input int b_delay,
                            input logic [1:0] bresp,
                            output logic [31:0] seen_wdata, output logic [3:0] seen_strb);
        int n;
        int last;
        @(negedge clock);
        lsu_wvalid = 1'b1; lsu_waddr = addr; lsu_wdata = data; lsu_wmask = mask;
        n = 0;
        do begin @(negedge clock); n++; #1; end while (!m_awvalid && n < 20);
        chk("aw_latency", 32'(n), 32'd1);
        chk("awaddr", m_awaddr, addr);
        chk("awlen", 32'(m_awlen), 32'd0);
        chk("awsize", 32'(m_awsize), 32'(model_size(mask)));
        chk("awburst", 32'(m_awburst), 32'd1);
        chk("awid", 32'(m_awid), 32'd1);
        chk1("wvalid_with_aw", m_wvalid, 1'b1);
        chk("wdata", m_wdata, model_wdata(data, mask));
        chk("wstrb", 32'(m_wstrb), 32'(model_strb(addr, mask)));
        chk1("wlast", m_wlast, 1'b1);
        seen_wdata = m_wdata;
        seen_strb  = m_wstrb;
        last = (aw_delay > w_delay) ? aw_delay : w_delay;
        for (int t = 0; t <= last; t++) begin
            if (t > 0) begin @(negedge clock); #1; end
            chk1("awvalid_phase", m_awvalid, t <= aw_delay);
            chk1("wvalid_phase", m_wvalid, t <= w_delay);
            chk1("wready_early", lsu_wready, 1'b0);
            m_awready = (t == aw_delay);
            m_wready  = (t == w_delay);
        end
        @(negedge clock);
        m_awready = 1'b0; m_wready = 1'b0;
        #1;
        chk1("bready", m_bready, 1'b1);
        chk1("aw_after_done", m_awvalid, 1'b0);
        chk1("w_after_done", m_wvalid, 1'b0);
        for (int i = 0; i < b_delay; i++) begin
            chk1("wready_wait_b", lsu_wready, 1'b0);
            @(negedge clock); #1;
        end
        m_bvalid = 1'b1; m_bresp = bresp;
        #1;
        chk1("lsu_wready_pulse", lsu_wready, 1'b1);
        @(negedge clock);
        m_bvalid = 1'b0; m_bresp = 2'b00; lsu_wvalid = 1'b0;
        #1;
        chk1("lsu_wready_drop", lsu_wready, 1'b0);
        chk1("bready_drop", m_bready, 1'b0);
`ifdef YSYX_LSU_ACCESS_ERR_EN
        chk1("access_err", access_err, bresp[1]);
        if (bresp[1]) chk("access_err_addr", access_err_addr, addr);
`endif
    endtask

    initial begin
        logic [31:0] first;
        logic [31:0] sw;
        logic [3:0]  ss;
        reset = 1'b1;
        lsu_rvalid = 1'b0; lsu_raddr = 32'h0; lsu_rlen = 8'h0; lsu_burst = 1'b0;
        lsu_rmask = 2'b00; lsu_rsign = 1'b0;
        lsu_wvalid = 1'b0; lsu_wdata = 32'h0; lsu_waddr = 32'h0; lsu_wmask = 2'b00;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00; m_rlast = 1'b0;
        m_rid = 4'd0; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        m_bid = 4'd1;

        repeat (3) @(negedge clock);
        #1;
        chk1("reset_arvalid", m_arvalid, 1'b0);
        chk1("reset_awvalid", m_awvalid, 1'b0);
        chk1("reset_wvalid", m_wvalid, 1'b0);
        chk1("reset_rready", m_rready, 1'b0);
        chk1("reset_bready", m_bready, 1'b0);
        chk1("reset_lsu_rready", lsu_rready, 1'b0);
        chk1("reset_lsu_wready", lsu_wready, 1'b0);
        chk("reset_lsu_rdata", lsu_rdata, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        do_read(32'h8000_0003, 8'd0, 1'b0, 2'b00, 1'b1, 32'h8012_3456, 0, 1'b0, -1, first);
        chk("lb_value", first, 32'hFFFF_FF80);
        do_read(32'h8000_0002, 8'd0, 1'b0, 2'b01, 1'b0, 32'hBEEF_1234, 1, 1'b0, -1, first);
        chk("lhu_value", first, 32'h0000_BEEF);
        do_read(32'h3000_0000, 8'd3, 1'b1, 2'b00, 1'b1, 32'h8765_4321, 0, 1'b1, -1, first);
        chk("refill_beat0", first, 32'h8765_4321);

        do_write(32'h8000_0001, 32'h0000_00AB, 2'b00, 0, 2, 1, 2'b00, sw, ss);
        chk("sb_wdata", sw, 32'hABAB_ABAB);
        chk("sb_wstrb", 32'(ss), 32'h2);
        do_write(32'h8000_0102, 32'h1234_5678, 2'b01, 2, 0, 0, 2'b10, sw, ss);
        chk("sh_wstrb", 32'(ss), 32'hC);

        // Read and write requested in the same cycle.
        lsu_waddr = 32'h9000_0000; lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 2'b10;
        g_dual = 1'b1;
        do_read(32'h9000_0010, 8'd1, 1'b1, 2'b10, 1'b0, 32'h1111_2222, 0, 1'b0, -1, first);
        g_dual = 1'b0;
        do_write(32'h9000_0000, 32'hCAFE_F00D, 2'b10, 1, 1, 0, 2'b00, sw, ss);
        chk("dual_wdata", sw, 32'hCAFE_F00D);

        for (int i = 0; i < 12; i++) begin
            logic        rb;
            logic [1:0]  rm;
            rb = ($urandom_range(0, 3) == 0);
            rm = 2'($urandom_range(0, 3));
            do_read($urandom, 8'($urandom_range(0, 5)), rb, rm, 1'($urandom_range(0, 1)),
                    $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1, first);
            do_write($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2),
                     $urandom_range(0, 2), $urandom_range(0, 2), 2'b00, sw, ss);
        end

        // Reset while the refill is in flight, then a normal load must still work.
        do_read(32'h3000_0040, 8'd3, 1'b1, 2'b10, 1'b0, 32'h0BAD_0001, 0, 1'b0, 0, first);
        do_read(32'h8000_0001, 8'd0, 1'b0, 2'b01, 1'b1, 32'h00F0_0000, 0, 1'b0, -1, first);
        chk("post_reset_lh", first, 32'hFFFF_F000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
